// File: rtl/video_timing_generator.sv
// Raster timing source: walks active/front/sync/back regions in x and y
// and presents registered de, hs, vs, x, y, sof, eol (+ o_frame with VIDEO_TIMING_FRAME_CNT_EN).
//
// Ports:
//   i_clk   pixel clock
//   i_rstn  asynchronous active-low reset
//   i_en    advance enable, one pixel per enabled edge
//   o_de    data enable, high in the active area
//   o_hs    hsync, at HS_POL while asserted
//   o_vs    vsync, at VS_POL while asserted
//   o_x     horizontal position, 0..H_TOTAL-1
//   o_y     vertical position, 0..V_TOTAL-1
//   o_sof   one-cycle pulse while (0,0) is presented
//   o_eol   one-cycle pulse while x=H_ACTIVE-1 of an active line is presented
//   o_frame completed frames mod 256 (VIDEO_TIMING_FRAME_CNT_EN only)
//
// Totals must be <= 1024 and every region length must be >= 1.
module video_timing_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_en,
  output logic       o_de,
  output logic       o_hs,
  output logic       o_vs,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_sof,
  output logic       o_eol
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0] o_frame
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  // Last count of each region.
  localparam logic [9:0] H_ACT_END = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_END  = 10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] H_SY_END  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_END     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_END = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_END  = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] V_SY_END  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_END     = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    ST_H_ACT,
    ST_H_FP,
    ST_H_SYNC,
    ST_H_BP
  } h_state_t;

  typedef enum logic [1:0] {
    ST_V_ACT,
    ST_V_FP,
    ST_V_SYNC,
    ST_V_BP
  } v_state_t;

  h_state_t   h_st, h_st_nxt;
  v_state_t   v_st, v_st_nxt;
  logic [9:0] h_cnt, h_cnt_nxt;
  logic [9:0] v_cnt, v_cnt_nxt;
  logic       h_wrap;
  logic       v_wrap;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h_st  <= ST_H_ACT;
      v_st  <= ST_V_ACT;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (i_en) begin
      h_st  <= h_st_nxt;
      v_st  <= v_st_nxt;
      h_cnt <= h_cnt_nxt;
      v_cnt <= v_cnt_nxt;
    end
  end

  always_comb begin
    h_wrap    = (h_cnt == H_END);
    v_wrap    = (v_cnt == V_END);
    h_cnt_nxt = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_cnt_nxt = v_cnt;
    h_st_nxt  = h_st;
    v_st_nxt  = v_st;

    unique case (h_st)
      ST_H_ACT:  if (h_cnt == H_ACT_END) h_st_nxt = ST_H_FP;
      ST_H_FP:   if (h_cnt == H_FP_END)  h_st_nxt = ST_H_SYNC;
      ST_H_SYNC: if (h_cnt == H_SY_END)  h_st_nxt = ST_H_BP;
      ST_H_BP:   if (h_wrap)             h_st_nxt = ST_H_ACT;
      default:                           h_st_nxt = ST_H_ACT;
    endcase

    // Vertical side only moves on the line wrap.
    if (h_wrap) begin
      v_cnt_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
      unique case (v_st)
        ST_V_ACT:  if (v_cnt == V_ACT_END) v_st_nxt = ST_V_FP;
        ST_V_FP:   if (v_cnt == V_FP_END)  v_st_nxt = ST_V_SYNC;
        ST_V_SYNC: if (v_cnt == V_SY_END)  v_st_nxt = ST_V_BP;
        ST_V_BP:   if (v_wrap)             v_st_nxt = ST_V_ACT;
        default:                           v_st_nxt = ST_V_ACT;
      endcase
    end
  end

  logic at_origin;
  assign at_origin = (h_cnt == 10'd0) && (v_cnt == 10'd0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_de  <= 1'b0;
      o_hs  <= ~HS_POL;
      o_vs  <= ~VS_POL;
      o_x   <= '0;
      o_y   <= '0;
      o_sof <= 1'b0;
      o_eol <= 1'b0;
    end else if (i_en) begin
      o_de  <= (h_st == ST_H_ACT) && (v_st == ST_V_ACT);
      o_hs  <= (h_st == ST_H_SYNC) ? HS_POL : ~HS_POL;
      o_vs  <= (v_st == ST_V_SYNC) ? VS_POL : ~VS_POL;
      o_x   <= h_cnt;
      o_y   <= v_cnt;
      o_sof <= at_origin;
      o_eol <= (h_cnt == H_ACT_END) && (v_st == ST_V_ACT);
    end else begin
      // Pulses last one presented pixel only.
      o_sof <= 1'b0;
      o_eol <= 1'b0;
    end
  end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  // The first (0,0) after reset opens frame 0 rather than closing one.
  logic started;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      started <= 1'b0;
      o_frame <= '0;
    end else if (i_en) begin
      started <= 1'b1;
      if (started && at_origin) o_frame <= o_frame + 8'd1;
    end
  end
`endif

endmodule
